// File: rtl/muldiv_pkg.sv
// rtl/muldiv_pkg.sv - shared op encoding, FSM states and default width for the multiply/divide unit
package muldiv_pkg;

   localparam int DEFAULT_WIDTH = 32;

   typedef enum logic [1:0] {
      MULT  = 2'b00,
      MULTU = 2'b01,
      DIV   = 2'b10,
      DIVU  = 2'b11
   } muldivOp_t;

   typedef enum logic [1:0] {
      IDLE = 2'b00,
      CALC = 2'b01,
      FIX  = 2'b10
   } muldivState_t;

endpackage

// File: rtl/muldiv_signfix.sv
// rtl/muldiv_signfix.sv - combinational conditional two's-complement negate (magnitude or sign restore)
module muldiv_signfix #(
   parameter int WIDTH = 32
) (
   input  logic [WIDTH-1:0] value,
   input  logic             negate,
   output logic [WIDTH-1:0] result
);

   assign result = negate ? (~value + WIDTH'(1)) : value;

endmodule

// File: rtl/muldiv_unit.sv
// rtl/muldiv_unit.sv - iterative MULT/MULTU/DIV/DIVU unit with architectural HI/LO, falling-edge state
module muldiv_unit
   import muldiv_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH,
   parameter int CNT_W = $clog2(WIDTH)
) (
   input  logic             CLK,
   input  logic             Reset_L,
   input  logic             start,
   input  logic [1:0]       op,
   input  logic [WIDTH-1:0] opA,
   input  logic [WIDTH-1:0] opB,
   input  logic             flush,
   input  logic             wrHi,
   input  logic             wrLo,
   input  logic [WIDTH-1:0] wrData,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo,
   output logic             busy,
   output logic             done
);

   muldivState_t state, nextState;
   muldivOp_t    opSel;
   logic             accept, finish, isSigned, isDivOp;
   logic             isDiv, signRes, signRem, divZero;
   logic [CNT_W-1:0] cnt;
   logic [2*WIDTH-1:0] acc, prodFix;
   logic [WIDTH-1:0] opnd, rem, magA, magB, quoFix, remFix;
   logic [WIDTH:0]   sum, shifted;
   logic [WIDTH-1:0] diff;
   logic             geq;

   assign opSel    = muldivOp_t'(op);
   assign isSigned = (opSel == MULT) || (opSel == DIV);
   assign isDivOp  = (opSel == DIV) || (opSel == DIVU);
   assign busy     = (state != IDLE);

   muldiv_signfix #(.WIDTH(WIDTH))   absA   (.value(opA), .negate(isSigned & opA[WIDTH-1]), .result(magA));
   muldiv_signfix #(.WIDTH(WIDTH))   absB   (.value(opB), .negate(isSigned & opB[WIDTH-1]), .result(magB));
   muldiv_signfix #(.WIDTH(2*WIDTH)) fixProd(.value(acc), .negate(signRes), .result(prodFix));
   muldiv_signfix #(.WIDTH(WIDTH))   fixQuo (.value(acc[WIDTH-1:0]), .negate(signRes), .result(quoFix));
   muldiv_signfix #(.WIDTH(WIDTH))   fixRem (.value(rem), .negate(signRem), .result(remFix));

   // Shift-add step: multiplier sits in acc low half and drains out as product bits shift in
   assign sum     = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, opnd} : '0);
   // Restoring step: W+1-bit trial remainder against the divisor
   assign shifted = {rem, acc[WIDTH-1]};
   assign geq     = (shifted >= {1'b0, opnd});
   assign diff    = shifted[WIDTH-1:0] - opnd;

   always_ff @(negedge CLK or negedge Reset_L) begin
      if (!Reset_L) state <= IDLE;
      else          state <= nextState;
   end

   always_comb begin
      nextState = state;
      accept    = 1'b0;
      finish    = 1'b0;
      case (state)
         IDLE: if (start && !flush) begin
            accept    = 1'b1;
            nextState = CALC;
         end
         CALC: if (flush)           nextState = IDLE;
               else if (cnt == '0)  nextState = FIX;
         FIX: begin
            nextState = IDLE;
            finish    = !flush;
         end
         default: nextState = IDLE;
      endcase
   end

   always_ff @(negedge CLK or negedge Reset_L) begin
      if (!Reset_L) begin
         cnt     <= '0;
         acc     <= '0;
         opnd    <= '0;
         rem     <= '0;
         isDiv   <= 1'b0;
         signRes <= 1'b0;
         signRem <= 1'b0;
         divZero <= 1'b0;
         hi      <= '0;
         lo      <= '0;
         done    <= 1'b0;
      end else begin
         done <= finish;
         if (accept) begin
            acc     <= {{WIDTH{1'b0}}, (isDivOp ? magA : magB)};
            opnd    <= isDivOp ? magB : magA;
            rem     <= '0;
            cnt     <= CNT_W'(WIDTH-1);
            isDiv   <= isDivOp;
            signRes <= isSigned & (opA[WIDTH-1] ^ opB[WIDTH-1]);
            signRem <= isSigned & opA[WIDTH-1];
            divZero <= (opB == '0);
         end else if (state == CALC) begin
            if (cnt != '0) cnt <= cnt - CNT_W'(1);
            if (isDiv) begin
               rem                <= geq ? diff : shifted[WIDTH-1:0];
               acc[WIDTH-1:0]     <= {acc[WIDTH-2:0], geq};
            end else begin
               acc <= {sum, acc[WIDTH-1:1]};
            end
         end
         if (finish) begin
            // Divide by zero leaves remainder = |opA|, so sign restore yields opA; quotient is forced
            hi <= isDiv ? remFix : prodFix[2*WIDTH-1:WIDTH];
            lo <= isDiv ? (divZero ? '1 : quoFix) : prodFix[WIDTH-1:0];
         end else if (state == IDLE) begin
            if (wrHi) hi <= wrData;
            if (wrLo) lo <= wrData;
         end
      end
   end

endmodule

// File: doc/muldiv_unit.md
MULDIV_UNIT -- requirements
Module: muldiv_unit

Interface
REQ-001 Parameter WIDTH, default 32, meaning operand, HI and LO width; legal values are even and at least 4.
REQ-002 Parameter CNT_W, default $clog2(WIDTH), meaning iteration-counter width.
REQ-003 CLK  input  1  clock; all state updates on the falling edge.
REQ-004 Reset_L  input  1  reset, asynchronous, active-low.
REQ-005 start  input  1  launch the operation on op, sampled only in IDLE.
REQ-006 op  input  2  operation select: 00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
REQ-007 opA  input  WIDTH  dividend or multiplicand (rs).
REQ-008 opB  input  WIDTH  divisor or multiplier (rt).
REQ-009 flush  input  1  cancel the in-flight operation.
REQ-010 wrHi, wrLo  input  1 each  MTHI / MTLO write strobes.
REQ-011 wrData  input  WIDTH  MTHI / MTLO write data.
REQ-012 hi, lo  output  WIDTH each  architectural HI and LO registers.
REQ-013 busy  output  1  high whenever state is not IDLE; the hazard unit stalls MFHI/MFLO/MULT/DIV on it.
REQ-014 done  output  1  one-cycle pulse when HI/LO have been updated by a completed operation.

Function
REQ-015 FSM states: IDLE, CALC, FIX.
- IDLE -> CALC: on start.
- CALC -> FIX: after WIDTH iterations.
- FIX -> IDLE: unconditionally.
REQ-016 On the edge that accepts start:
- latch the magnitudes of opA and opB (two's-complement absolute value for MULT/DIV, raw for MULTU/DIVU);
- latch the result-sign and remainder-sign flags;
- set the counter to WIDTH-1.
REQ-017 Multiply is radix-2 shift-add, one multiplier bit per CALC edge, with a 2*WIDTH-bit accumulator.
REQ-018 Divide is restoring, one quotient bit per CALC edge: WIDTH+1-bit partial remainder, quotient shifted into the low register.
REQ-019 FIX applies the sign correction and writes HI/LO:
- multiply: HI = product[2W-1:W], LO = product[W-1:0];
- divide: HI = remainder, LO = quotient;
- remainder sign follows the dividend; quotient sign is the XOR of the operand signs.
REQ-020 Latency: start accepted at edge N; HI/LO updated at edge N+WIDTH+1; done high for exactly the cycle following that edge.
REQ-021 busy rises at edge N and falls at edge N+WIDTH+1.
REQ-022 Divide by zero (DIV or DIVU): LO = all ones, HI = opA; full latency still applies.
REQ-023 DIV of the most-negative value by -1: LO = the most-negative value, HI = 0.
REQ-024 start while busy is ignored.
REQ-025 A change to op, opA or opB after acceptance does not affect the result.
REQ-026 flush in CALC or FIX: return to IDLE at that edge; HI/LO unchanged; no done pulse.
REQ-027 flush together with start in IDLE: start is ignored.
REQ-028 wrHi/wrLo in IDLE write wrData at that edge and take effect before any start on the same edge.
REQ-029 wrHi/wrLo while busy are ignored.
REQ-030 wrHi and wrLo together write both registers.
REQ-031 hi/lo are driven straight from registers; no combinational path from any input to them.

Reset
REQ-032 Reset_L low asynchronously forces:
- state IDLE, counter 0;
- hi = 0, lo = 0, busy = 0, done = 0;
- all datapath registers 0.
REQ-033 Reset mid-operation discards the operation; the first edge after release with start high launches a new one.

Structure
REQ-034 The shared package muldiv_pkg holds:
- the op encoding enum (MULT, MULTU, DIV, DIVU);
- the FSM state enum;
- the default WIDTH constant.
REQ-035 The processor's control decoder and hazard unit import the same op encoding from muldiv_pkg.
REQ-036 One sub-module, muldiv_signfix, performs combinational magnitude/negate, parametrised by WIDTH, and is instantiated for operand entry and for FIX.
REQ-037 No other sub-modules.

Verification (WIDTH=32)
REQ-038 MULT opA=0xFFFFFFFE (-2), opB=0x00000003 -> after 33 edges hi=0xFFFFFFFF, lo=0xFFFFFFFA, done pulses once.
REQ-039 MULTU opA=0xFFFFFFFF, opB=0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001.
REQ-040 DIV opA=0xFFFFFFF9 (-7), opB=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF.
REQ-041 DIVU opA=100, opB=0 -> lo=0xFFFFFFFF, hi=100.
REQ-042 DIV opA=0x80000000, opB=0xFFFFFFFF -> lo=0x80000000, hi=0.
REQ-043 MTHI 0x1234 then DIVU 7/2 with flush at CALC edge 10 -> hi=0x1234, lo=0, no done; a following DIVU 7/2 gives lo=3, hi=1.
